// File: rtl/ram_banked_arb_pkg.sv
// Shared types and address helpers for the banked RAM arbiter.
package ram_pkg;

    // Which side wins the next same-bank read/write conflict.
    typedef enum logic {
        PRIO_WR = 1'b0,
        PRIO_RD = 1'b1
    } prio_t;

    // Default bank-select width; four interleaved banks.
    localparam int BANK_W = 2;

    // Low-bit interleave: the bank is the low bank_w bits of the word address.
    function automatic int unsigned bank_of(input int unsigned addr, input int unsigned bank_w);
        return addr & ((32'd1 << bank_w) - 32'd1);
    endfunction

    // The row inside a bank is what remains above the bank-select bits.
    function automatic int unsigned row_of(input int unsigned addr, input int unsigned bank_w);
        return addr >> bank_w;
    endfunction

endpackage

// File: rtl/ram_banked_arb_if.sv
// Write, read-request and read-data channels of the banked RAM.
interface ram_banked_arb_if #(
    parameter int SRAM_WIDTH = 256,
    parameter int SRAM_BYTE  = 2,
    parameter int ADDR_WIDTH = 8
);
    logic                  wr_val;
    logic                  wr_rdy;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [SRAM_BYTE-1:0]  wr_mask;
    logic [SRAM_WIDTH-1:0] wr_dat;
    logic                  rd_val;
    logic                  rd_rdy;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_dat_val;
    logic                  rd_dat_rdy;
    logic [SRAM_WIDTH-1:0] rd_dat;

    modport master (
        output wr_val, wr_addr, wr_mask, wr_dat, rd_val, rd_addr, rd_dat_rdy,
        input  wr_rdy, rd_rdy, rd_dat_val, rd_dat
    );

    modport slave (
        input  wr_val, wr_addr, wr_mask, wr_dat, rd_val, rd_addr, rd_dat_rdy,
        output wr_rdy, rd_rdy, rd_dat_val, rd_dat
    );
endinterface

// File: rtl/ram_banked_arb_bank.sv
// One RAM bank: masked write, registered Q, single- or dual-port.
module ram_bank_mdl #(
    parameter int SRAM_BIT  = 128,
    parameter int SRAM_BYTE = 2,
    parameter int SRAM_WORD = 64,
    parameter int DUAL_PORT = 0,
    parameter int ROW_W     = $clog2(SRAM_WORD)
) (
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [ROW_W-1:0]              wr_row,
    input  logic [SRAM_BYTE-1:0]          wr_mask,
    input  logic [SRAM_BIT*SRAM_BYTE-1:0] wr_dat,
    input  logic                          rd_en,
    input  logic [ROW_W-1:0]              rd_row,
    output logic [SRAM_BIT*SRAM_BYTE-1:0] q
);
    logic [SRAM_BIT*SRAM_BYTE-1:0] mem [SRAM_WORD];

    if (DUAL_PORT != 0) begin : g_dp
        // Independent ports; a same-row read sees the old word.
        always_ff @(posedge clk) begin
            if (rd_en) begin
                q <= mem[rd_row];
            end
            if (wr_en) begin
                for (int b = 0; b < SRAM_BYTE; b++) begin
                    if (wr_mask[b]) begin
                        mem[wr_row][b*SRAM_BIT +: SRAM_BIT] <= wr_dat[b*SRAM_BIT +: SRAM_BIT];
                    end
                end
            end
        end
    end else begin : g_sp
        logic             ceb;
        logic [ROW_W-1:0] addr;

        // The arbiter never enables both sides of a single-port bank at once.
        assign ceb  = !(wr_en || rd_en);
        assign addr = wr_en ? wr_row : rd_row;

        // Single shared port: write when granted, otherwise read.
        always_ff @(posedge clk) begin
            if (!ceb) begin
                if (wr_en) begin
                    for (int b = 0; b < SRAM_BYTE; b++) begin
                        if (wr_mask[b]) begin
                            mem[addr][b*SRAM_BIT +: SRAM_BIT] <= wr_dat[b*SRAM_BIT +: SRAM_BIT];
                        end
                    end
                end else begin
                    q <= mem[addr];
                end
            end
        end
    end
endmodule

// File: rtl/ram_banked_arb.sv
// Banked RAM with valid/ready channels, conflict arbitration and read-data hold.
module ram_banked_arb
    import ram_pkg::*;
#(
    parameter int SRAM_BIT   = 128,
    parameter int SRAM_BYTE  = 2,
    parameter int SRAM_WORD  = 64,
    parameter int NUM_BANK   = 1 << BANK_W,
    parameter int DUAL_PORT  = 0,
    parameter int SRAM_WIDTH = SRAM_BIT * SRAM_BYTE,
    parameter int ADDR_WIDTH = $clog2(SRAM_WORD * NUM_BANK)
) (
    input  logic             clk,
    input  logic             rst_n,
    ram_banked_arb_if.slave  bus
);
    localparam int unsigned SHIFT   = $clog2(NUM_BANK);
    localparam int          BANK_IW = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int          ROW_W   = $clog2(SRAM_WORD);

    logic [ADDR_WIDTH-1:0] wr_addr_w, rd_addr_w;
    logic [BANK_IW-1:0]    wr_bank, rd_bank, sel_bank;
    logic [ROW_W-1:0]      wr_row, rd_row;
    logic                  rd_free, conflict, wr_fire, rd_fire;
    logic                  rd_dat_val_q, fresh;
    prio_t                 prio;
    logic [SRAM_WIDTH-1:0] hold;
    logic [SRAM_WIDTH-1:0] bank_q [NUM_BANK];

    assign wr_addr_w = bus.wr_addr;
    assign rd_addr_w = bus.rd_addr;
    assign wr_bank   = BANK_IW'(bank_of(32'(wr_addr_w), SHIFT));
    assign rd_bank   = BANK_IW'(bank_of(32'(rd_addr_w), SHIFT));
    assign wr_row    = ROW_W'(row_of(32'(wr_addr_w), SHIFT));
    assign rd_row    = ROW_W'(row_of(32'(rd_addr_w), SHIFT));

    // A read stalled by output backpressure is not competing for the bank.
    assign rd_free  = !rd_dat_val_q || bus.rd_dat_rdy;
    assign conflict = (DUAL_PORT == 0) && bus.wr_val && bus.rd_val && rd_free
                      && (wr_bank == rd_bank);

    assign bus.wr_rdy = !conflict || (prio == PRIO_WR);
    assign bus.rd_rdy = rd_free && !(conflict && (prio == PRIO_WR));
    assign wr_fire    = bus.wr_val && bus.wr_rdy;
    assign rd_fire    = bus.rd_val && bus.rd_rdy;

    // Fresh data comes straight from the bank; after a stall it comes from hold.
    assign bus.rd_dat     = fresh ? bank_q[sel_bank] : hold;
    assign bus.rd_dat_val = rd_dat_val_q;

    for (genvar i = 0; i < NUM_BANK; i++) begin : g_bank
        ram_bank_mdl #(
            .SRAM_BIT  (SRAM_BIT),
            .SRAM_BYTE (SRAM_BYTE),
            .SRAM_WORD (SRAM_WORD),
            .DUAL_PORT (DUAL_PORT),
            .ROW_W     (ROW_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_fire && (wr_bank == BANK_IW'(i))),
            .wr_row  (wr_row),
            .wr_mask (bus.wr_mask),
            .wr_dat  (bus.wr_dat),
            .rd_en   (rd_fire && (rd_bank == BANK_IW'(i))),
            .rd_row  (rd_row),
            .q       (bank_q[i])
        );
    end

    // Remember which bank the outstanding read was issued to.
    always_ff @(posedge clk) begin
        if (rd_fire) begin
            sel_bank <= rd_bank;
        end
    end

    // Priority pointer, read-data valid and the backpressure hold register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio         <= PRIO_WR;
            rd_dat_val_q <= 1'b0;
            fresh        <= 1'b0;
            hold         <= '0;
        end else begin
            if (conflict) begin
                prio <= (prio == PRIO_WR) ? PRIO_RD : PRIO_WR;
            end
            if (rd_fire) begin
                rd_dat_val_q <= 1'b1;
            end else if (bus.rd_dat_rdy) begin
                rd_dat_val_q <= 1'b0;
            end
            fresh <= rd_fire;
            if (rd_dat_val_q && !bus.rd_dat_rdy && fresh) begin
                hold <= bank_q[sel_bank];
            end
        end
    end
endmodule
